// File: rtl/bus_hs_pkg.sv
// Shared definitions for the valid/ready bus-handshake library
// (forward pipeline and backward skid buffer).
package bus_hs_pkg;

    localparam int unsigned L_DEFAULT = 8;

    // Bits needed to hold values 0..value-1; used for occupancy counters.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/forward_pipe_stage.sv
// One forward-registered valid/data stage; ready passes back combinationally
// and an empty stage always accepts, which collapses bubbles.
module forward_pipe_stage
    import bus_hs_pkg::*;
#(
    parameter int unsigned L = L_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [L-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [L-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_q;
    logic         valid_d;
    logic [L-1:0] data_q;
    logic [L-1:0] data_d;

    always_comb begin
        in_ready = out_ready | ~valid_q;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            // Data only moves with a valid beat; an invalid slot keeps stale data.
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/forward_pipe.sv
// Forward-registered valid/ready pipeline of DEPTH stages with combinational
// ready and an occupancy counter.
module forward_pipe
    import bus_hs_pkg::*;
#(
    parameter int unsigned L     = L_DEFAULT,
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_f,
    output logic                      ready_f,
    input  logic [L-1:0]              data_f,
    output logic                      valid_b,
    input  logic                      ready_b,
    output logic [L-1:0]              data_b,
    output logic [clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = clog2(DEPTH + 1);

    // Element i is the link feeding stage i; element DEPTH is the output side.
    logic         vld [DEPTH+1];
    logic         rdy [DEPTH+1];
    logic [L-1:0] dat [DEPTH+1];

    assign vld[0]     = valid_f;
    assign dat[0]     = data_f;
    assign rdy[DEPTH] = ready_b;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        forward_pipe_stage #(
            .L(L)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst),
            .in_valid (vld[i]),
            .in_data  (dat[i]),
            .in_ready (rdy[i]),
            .out_valid(vld[i+1]),
            .out_data (dat[i+1]),
            .out_ready(rdy[i+1])
        );
    end

    assign ready_f = rdy[0];
    assign valid_b = vld[DEPTH];
    assign data_b  = dat[DEPTH];

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push;
    logic          pop;

    always_comb begin
        push    = valid_f & ready_f;
        pop     = valid_b & ready_b;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_forward_pipe.sv
// Scoreboard bench for forward_pipe (L=8, DEPTH=2): accepted beats are queued
// and compared in order as they leave the pipe.
module tb_forward_pipe;

    localparam int unsigned L     = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_f;
    logic          ready_f;
    logic [L-1:0]  data_f;
    logic          valid_b;
    logic          ready_b;
    logic [L-1:0]  data_b;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;
    logic [L-1:0] sb_q[$];

    forward_pipe #(
        .L    (L),
        .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .valid_f(valid_f),
        .ready_f(ready_f),
        .data_f (data_f),
        .valid_b(valid_b),
        .ready_b(ready_b),
        .data_b (data_b),
        .count  (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: waits to mid-cycle, then scores this cycle's handshakes.
    task automatic settle();
        #4;
        if (rst) begin
            if (valid_b && ready_b) begin
                if (sb_q.size() == 0)
                    check_val("sb_unexpected_beat", 32'(sb_q.size()), 32'd1);
                else
                    check_val("sb_data", 32'(data_b), 32'(sb_q.pop_front()));
            end
            if (valid_f && ready_f)
                sb_q.push_back(data_f);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        valid_f = 1'b0;
        ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            done = !valid_b && (count == 0) && (sb_q.size() == 0);
            advance();
            if (done) break;
        end
        check_val("drain_count", 32'(count), 32'd0);
        check_val("drain_valid_b", 32'(valid_b), 32'd0);
        check_val("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        valid_f = 1'b1;
        data_f  = 8'hAA;
        ready_b = 1'b1;
        advance();

        // Reset held with a beat offered
        for (int c = 0; c < 3; c++) begin
            settle();
            check_val("rst_valid_b", 32'(valid_b), 32'd0);
            check_val("rst_data_b", 32'(data_b), 32'd0);
            check_val("rst_count", 32'(count), 32'd0);
            check_val("rst_ready_f", 32'(ready_f), 32'd1);
            advance();
        end
        rst = 1'b1;
        settle();
        check_val("aa_ready_f", 32'(ready_f), 32'd1);
        advance();
        valid_f = 1'b0;
        settle();
        check_val("aa_lat_early", 32'(valid_b), 32'd0);
        advance();
        settle();
        check_val("aa_lat_valid", 32'(valid_b), 32'd1);
        check_val("aa_lat_data", 32'(data_b), 32'hAA);
        advance();
        drain();

        // Streaming 01..10 back to back
        ready_b = 1'b1;
        for (int k = 0; k < 16; k++) begin
            valid_f = 1'b1;
            data_f  = 8'(k + 1);
            settle();
            check_val("stream_ready_f", 32'(ready_f), 32'd1);
            if (k >= 2) begin
                check_val("stream_count", 32'(count), 32'd2);
                check_val("stream_valid_b", 32'(valid_b), 32'd1);
            end
            advance();
        end
        valid_f = 1'b0;
        settle();
        check_val("stream_tail_valid", 32'(valid_b), 32'd1);
        advance();
        drain();

        // Stall and fill
        ready_b = 1'b0;
        valid_f = 1'b1;
        data_f  = 8'h11;
        settle();
        check_val("stall_acc11", 32'(ready_f), 32'd1);
        advance();
        data_f = 8'h22;
        settle();
        check_val("stall_acc22", 32'(ready_f), 32'd1);
        advance();
        data_f = 8'h33;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_val("stall_ready_f", 32'(ready_f), 32'd0);
            check_val("stall_count", 32'(count), 32'd2);
            check_val("stall_valid_b", 32'(valid_b), 32'd1);
            check_val("stall_data_b", 32'(data_b), 32'h11);
            advance();
        end
        ready_b = 1'b1;
        settle();
        check_val("release_ready_f", 32'(ready_f), 32'd1);
        advance();
        drain();

        // Bubble collapse, then simultaneous transfer when full
        ready_b = 1'b0;
        valid_f = 1'b1;
        data_f  = 8'h55;
        settle();
        advance();
        valid_f = 1'b0;
        settle();
        advance();
        settle();
        check_val("bubble_count1", 32'(count), 32'd1);
        check_val("bubble_valid_b", 32'(valid_b), 32'd1);
        check_val("bubble_data_b", 32'(data_b), 32'h55);
        valid_f = 1'b1;
        data_f  = 8'h66;
        #0;
        check_val("bubble_ready_f", 32'(ready_f), 32'd1);
        if (ready_f)
            sb_q.push_back(data_f);
        advance();
        valid_f = 1'b1;
        data_f  = 8'h77;
        ready_b = 1'b1;
        settle();
        check_val("bubble_count2", 32'(count), 32'd2);
        check_val("full_ready_f", 32'(ready_f), 32'd1);
        advance();
        valid_f = 1'b0;
        settle();
        check_val("full_count_kept", 32'(count), 32'd2);
        advance();
        drain();

        // Async reset mid-stream
        ready_b = 1'b0;
        valid_f = 1'b1;
        data_f  = 8'h88;
        settle();
        advance();
        data_f = 8'h99;
        settle();
        advance();
        valid_f = 1'b0;
        check_val("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_valid_b", 32'(valid_b), 32'd0);
        check_val("async_count", 32'(count), 32'd0);
        sb_q.delete();
        advance();
        advance();
        rst     = 1'b1;
        ready_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check_val("post_rst_no_stale", 32'(valid_b), 32'd0);
            advance();
        end
        valid_f = 1'b1;
        data_f  = 8'hBB;
        settle();
        advance();
        drain();

        check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forward_pipe.md
# forward_pipe

Forward-registered valid/ready pipeline: a chain of DEPTH register stages on `valid` and `data`, with `ready` returned combinationally and bubbles collapsed. It is the forward-direction counterpart of the backward skid buffer in the bus-handshake library. Timing is broken on the forward path (valid/data); the backward (ready) path is left combinational. It sits between a producer and a consumer that both use the same `valid`/`ready`/`data` handshake.

## Interface
- `L`, 8, data width in bits (≥1)
- `DEPTH`, 2, number of register stages (≥1)
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous active-low reset
- `valid_f` in 1, upstream valid
- `ready_f` out 1, upstream ready (combinational)
- `data_f` in L, upstream data
- `valid_b` out 1, downstream valid (registered)
- `ready_b` in 1, downstream ready
- `data_b` out L, downstream data (registered)
- `count` out $clog2(DEPTH+1), number of occupied stages (registered)

## Operation
- Stage i (0 = input side, DEPTH-1 = output side) holds `v[i]` and `d[i]`.
- Stage ready: `r[DEPTH-1] = ready_b | ~v[DEPTH-1]`; `r[i] = r[i+1] | ~v[i]`; `ready_f = r[0]`.
- On a clock edge where `r[i]` is 1:
  - stage i loads `v[i-1]`/`d[i-1]`; stage 0 loads `valid_f`/`data_f`.
  - If the loaded valid is 0, `d[i]` may hold its old value; there is no data requirement when invalid.
- When `r[i]` is 0 the stage holds. This gives bubble collapsing: an empty stage accepts even while the output is stalled.
- `valid_b = v[DEPTH-1]`, `data_b = d[DEPTH-1]`.
- `count` tracks occupancy:
  - +1 on an upstream transfer (`valid_f & ready_f`)
  - −1 on a downstream transfer (`valid_b & ready_b`)
  - unchanged when both or neither occur
  - never exceeds DEPTH and never underflows
- Reset (async assert, sync release on clk): all `v`=0, all `d`=0, `count`=0. Outputs after reset: `valid_b`=0, `data_b`=0, `ready_f`=1.
- Reset mid-operation discards all in-flight beats immediately. No partial beat is emitted.

## Timing
- Latency: a beat accepted at edge n appears on `valid_b`/`data_b` after edge n+DEPTH−1 when unstalled, i.e. it is visible DEPTH cycles after it was presented.
- Throughput: one beat per cycle sustained while `ready_b`=1.
- `ready_f` depends combinationally on `ready_b` and the stage valids. There is no combinational path from `valid_f`/`data_f` to any output.
- Handshake rules on the output side:
  - Once `valid_b`=1 it stays 1 and `data_b` stays stable until `ready_b`=1 at a clock edge.
  - `valid_b` never depends on `ready_b` in the same cycle.
- Full, with `ready_b`=0: `ready_f`=0 and `count`=DEPTH.
- Full, with `ready_b`=1 in the same cycle: `ready_f`=1, an input and an output transfer occur together, and `count` is unchanged.
- Empty: `valid_b`=0 and `count`=0. `ready_f`=1 regardless of `ready_b`.
- Ordering: beats leave in exactly the order accepted, with no loss or duplication.

## Structure
- The shared package `bus_hs_pkg` holds:
  - `L_DEFAULT` = 8
  - the `clog2` width helper, used for `count`, shared with the backward buffer
- Sub-module `forward_pipe_stage`:
  - one valid/data register with async active-low reset
  - inputs `in_valid`, `in_data`, `out_ready`
  - outputs `out_valid`, `out_data`, `in_ready`
- `forward_pipe` instantiates DEPTH stages in a generate loop and owns the `count` register.

## Test plan
- **Reset:** hold `rst`=0 with `valid_f`=1, `data_f`=8'hAA for 3 cycles. Required: `valid_b`=0, `data_b`=0, `count`=0, `ready_f`=1. After release, 8'hAA emerges DEPTH cycles later.
- **Streaming (DEPTH=2):** send 8'h01..8'h10 back-to-back with `ready_b`=1. Required: `data_b` shows 01..10 on consecutive cycles starting 2 cycles after the first accept, with `count` steady at 2.
- **Stall and fill:** set `ready_b`=0 and offer 8'h11, 8'h22, 8'h33. Required:
  - 11 and 22 are accepted; `ready_f` drops to 0 with 33 pending; `count`=2.
  - `data_b` holds 11 with `valid_b`=1 throughout the stall.
  - Releasing `ready_b` yields 11, 22, 33 in order.
- **Bubble collapse:** with a single beat 8'h55 stalled at the output (`count`=1, `ready_b`=0), offer 8'h66. Required: it is accepted the same cycle and `count` becomes 2.
- **Simultaneous transfer when full:** `count`=2, `ready_b`=1, `valid_f`=1. Required: `ready_f`=1, one beat in and one beat out, `count` stays 2.
- **Async reset mid-stream:** assert `rst` between clock edges while `count`=2. Required: `valid_b` and `count` go to 0 immediately, without waiting for a clock edge, and no stale beat appears after release.
